// File: rtl/mac_acc_ctrl.sv
// Dot-product accumulation controller: steers an external adder, counts terms,
// tracks signed overflow and holds each finished sum until the consumer takes it.
module mac_acc_ctrl #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    input  logic              acc_clr,
    output logic [PROD_W-1:0] add_a,
    output logic [ACC_W-1:0]  add_b,
    input  logic [ACC_W-1:0]  add_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic {StAcc, StDone} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_ovf;

    logic               w_accept;
    logic               w_ovf_now;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign add_a     = in_prod;
    assign add_b     = r_acc;
    assign in_ready  = (r_state == StAcc) && !acc_clr;
    assign out_valid = (r_state == StDone);
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

    assign w_accept  = in_valid && in_ready;
    // Same-sign operands producing a result of the other sign.
    assign w_ovf_now = (add_a[PROD_W-1] == add_b[ACC_W-1]) &&
                       (add_z[ACC_W-1] != add_b[ACC_W-1]);
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StAcc:   if (w_accept && in_last) w_state_d = StDone;
            StDone:  if (out_ready) w_state_d = StAcc;
            default: w_state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StAcc;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StAcc && acc_clr) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_accept) begin
                if (in_last) begin
                    r_out_sum   <= add_z;
                    r_out_count <= w_cnt_inc;
                    r_out_ovf   <= r_ovf | w_ovf_now;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_ovf       <= 1'b0;
                end else begin
                    r_acc <= add_z;
                    r_cnt <= w_cnt_inc;
                    r_ovf <= r_ovf | w_ovf_now;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_acc_ctrl.sv
// Directed bench for mac_acc_ctrl; the external adder is modelled here as
// z = b + sign-extend(a).
module tb_mac_acc_ctrl;

    localparam int unsigned PROD_W = 16;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              acc_clr;
    logic [PROD_W-1:0] add_a;
    logic [ACC_W-1:0]  add_b;
    logic [ACC_W-1:0]  add_z;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign add_z = add_b + {{(ACC_W-PROD_W){add_a[PROD_W-1]}}, add_a};

    mac_acc_ctrl #(
        .PROD_W(PROD_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_prod  (in_prod),
        .in_last  (in_last),
        .acc_clr  (acc_clr),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_z    (add_z),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_count(out_count),
        .out_ovf  (out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] sum,
                                input logic [31:0] cnt, input logic ovf);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"}, {8'd0, out_sum}, sum);
        check({tag, "_count"}, {24'd0, out_count}, cnt);
        check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, ovf});
    endtask

    // Presents one term from a negedge and returns at the negedge after its accept.
    task automatic push(input logic [PROD_W-1:0] p, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("consume_valid", {31'd0, out_valid}, 32'd0);
        check("consume_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_zeroed(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_sum"}, {8'd0, out_sum}, 32'd0);
        check({tag, "_count"}, {24'd0, out_count}, 32'd0);
        check({tag, "_ovf"}, {31'd0, out_ovf}, 32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_zeroed(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b0;
        #1;
        check_zeroed("reset");
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic sum.
        push(16'h0010, 1'b0);
        push(16'h0020, 1'b0);
        push(16'h0030, 1'b1);
        check_result("basic", 32'h60, 32'd3, 1'b0);
        check("done_in_ready", {31'd0, in_ready}, 32'd0);

        // Backpressure with a pending single-term transfer on the input.
        in_valid = 1'b1;
        in_prod  = 16'h0004;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_result("bp_hold", 32'h60, 32'd3, 1'b0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("bp_single", 32'h4, 32'd1, 1'b0);
        consume();

        // Negative terms.
        push(16'hFFFF, 1'b0);
        push(16'hFFFE, 1'b1);
        check_result("neg", 32'hFFFFFD, 32'd2, 1'b0);
        consume();

        // Overflow and count saturation.
        for (int i = 0; i < 256; i++) push(16'h7FFF, 1'b0);
        push(16'h7FFF, 1'b1);
        check_result("sat", 32'h807EFF, 32'd255, 1'b1);
        consume();
        push(16'h0001, 1'b1);
        check_result("post_sat", 32'h1, 32'd1, 1'b0);
        consume();

        // Abort, with a term offered during the clear cycle that must be dropped.
        push(16'h0005, 1'b0);
        push(16'h0007, 1'b0);
        acc_clr  = 1'b1;
        in_valid = 1'b1;
        in_prod  = 16'h0100;
        #1;
        check("clr_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        acc_clr  = 1'b0;
        in_valid = 1'b0;
        push(16'h0003, 1'b1);
        check_result("abort", 32'h3, 32'd1, 1'b0);
        consume();

        // out_ready while accumulating is ignored.
        out_ready = 1'b1;
        push(16'h0002, 1'b0);
        out_ready = 1'b0;
        push(16'h0003, 1'b1);
        check_result("rdy_in_acc", 32'h5, 32'd2, 1'b0);
        consume();

        // Reset mid-accumulation.
        push(16'h0011, 1'b0);
        push(16'h0022, 1'b0);
        pulse_reset("rst_mid");
        push(16'h0005, 1'b1);
        check_result("after_rst_mid", 32'h5, 32'd1, 1'b0);
        consume();

        // Reset while a result is pending.
        push(16'h0009, 1'b1);
        check_result("pre_rst_done", 32'h9, 32'd1, 1'b0);
        pulse_reset("rst_done");
        push(16'h0006, 1'b1);
        check_result("after_rst_done", 32'h6, 32'd1, 1'b0);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
